pipe_id_issue: RTL

Decode-to-execute issue stage for the five-stage pipelined CPU. Owns the ID/EX pipeline register that drives the execute stage's operand and control inputs (ea, eb, eimm, esa, epc4, ealuc, ealuimm, eshift, ejal, ern0). Resolves RAW hazards by forwarding from the execute and memory stages. Detects load-use hazards, stalls decode and inserts bubbles. Also accepts branch/jump flushes and keeps a saturating stall counter for performance debug.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/pipe_fwd_sel.sv | 50 +++++
 rtl/pipe_id_issue.sv | 128 ++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared pipeline types: forward-select codes and bubble record.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package cpu_pkg;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_EALU = 2'b01;
    localparam logic [1:0] FWD_MALU = 2'b10;
    localparam logic [1:0] FWD_MMO  = 2'b11;

    // Control fields of the ID/EX register that a bubble must neutralise.
    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic [4:0] rn0;
    } ctrl_t;

    localparam ctrl_t c_BUBBLE = '{wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0,
                                   jal: 1'b0, rn0: 5'd0};

endpackage

`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
// ============================================================================
// Module      : pipe_fwd_sel
// Description : Operand forward select for one source register (E over M).
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_fwd_sel
    import cpu_pkg::*;
(
    input  logic [4:0]  i_src,
    input  logic [31:0] i_dq,
    input  logic        i_ewreg,
    input  logic        i_em2reg,
    input  logic [4:0]  i_ern,
    input  logic [31:0] i_ealu,
    input  logic        i_mwreg,
    input  logic        i_mm2reg,
    input  logic [4:0]  i_mrn,
    input  logic [31:0] i_malu,
    input  logic [31:0] i_mmo,
    output logic [1:0]  o_sel,
    output logic [31:0] o_fwd
);

    // $0 is hardwired zero, so it never takes a forwarded value.
    always_comb begin
        o_sel = FWD_REG;
        if (i_src != 5'd0) begin
            if (i_ewreg && !i_em2reg && (i_ern == i_src))
                o_sel = FWD_EALU;
            else if (i_mwreg && (i_mrn == i_src))
                o_sel = i_mm2reg ? FWD_MMO : FWD_MALU;
        end
    end

    always_comb begin
        o_fwd = i_dq;
        case (o_sel)
            FWD_EALU: o_fwd = i_ealu;
            FWD_MALU: o_fwd = i_malu;
            FWD_MMO:  o_fwd = i_mmo;
            default:  o_fwd = i_dq;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipe_id_issue.sv
// ============================================================================
// Module      : pipe_id_issue
// Description : ID/EX issue stage: forwarding, load-use stall, flush, stall count.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module pipe_id_issue
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      dpc4,
    input  logic [31:0]      dqa,
    input  logic [31:0]      dqb,
    input  logic [31:0]      dimm,
    input  logic [31:0]      dsa,
    input  logic [4:0]       drs,
    input  logic [4:0]       drt,
    input  logic [4:0]       drn0,
    input  logic             duse_rs,
    input  logic             duse_rt,
    input  logic [3:0]       daluc,
    input  logic             daluimm,
    input  logic             dshift,
    input  logic             djal,
    input  logic             dwreg,
    input  logic             dm2reg,
    input  logic             dwmem,
    input  logic             dflush,
    input  logic [31:0]      ealu,
    input  logic [4:0]       ern,
    input  logic [4:0]       mrn,
    input  logic             mwreg,
    input  logic             mm2reg,
    input  logic [31:0]      malu,
    input  logic [31:0]      mmo,
    output logic             dstall,
    output logic [31:0]      ea,
    output logic [31:0]      eb,
    output logic [31:0]      eimm,
    output logic [31:0]      esa,
    output logic [31:0]      epc4,
    output logic [4:0]       ern0,
    output logic [3:0]       ealuc,
    output logic             ealuimm,
    output logic             eshift,
    output logic             ejal,
    output logic             ewreg,
    output logic             em2reg,
    output logic             ewmem,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]  w_sel_a;
    logic [1:0]  w_sel_b;
    logic [31:0] w_fwd_a;
    logic [31:0] w_fwd_b;
    logic        w_unused;
    ctrl_t       w_dctrl;
    ctrl_t       w_next_ctrl;

    pipe_fwd_sel u_fwd_a (
        .i_src    (drs),     .i_dq     (dqa),
        .i_ewreg  (ewreg),   .i_em2reg (em2reg), .i_ern (ern), .i_ealu (ealu),
        .i_mwreg  (mwreg),   .i_mm2reg (mm2reg), .i_mrn (mrn),
        .i_malu   (malu),    .i_mmo    (mmo),
        .o_sel    (w_sel_a), .o_fwd    (w_fwd_a)
    );

    pipe_fwd_sel u_fwd_b (
        .i_src    (drt),     .i_dq     (dqb),
        .i_ewreg  (ewreg),   .i_em2reg (em2reg), .i_ern (ern), .i_ealu (ealu),
        .i_mwreg  (mwreg),   .i_mm2reg (mm2reg), .i_mrn (mrn),
        .i_malu   (malu),    .i_mmo    (mmo),
        .o_sel    (w_sel_b), .o_fwd    (w_fwd_b)
    );

    // Select codes are a debug view only; the data path uses the forwarded values.
    assign w_unused = ^{w_sel_a, w_sel_b};

    // A load in E cannot forward until it reaches M, so decode waits one cycle.
    assign dstall = ~reset & ewreg & em2reg & (ern != 5'd0) &
                    ((duse_rs & (ern == drs)) | (duse_rt & (ern == drt)));

    assign w_dctrl     = '{wreg: dwreg, m2reg: dm2reg, wmem: dwmem,
                           jal: djal, rn0: drn0};
    assign w_next_ctrl = (dflush | dstall) ? c_BUBBLE : w_dctrl;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ea        <= '0;
            eb        <= '0;
            eimm      <= '0;
            esa       <= '0;
            epc4      <= '0;
            ealuc     <= '0;
            ealuimm   <= 1'b0;
            eshift    <= 1'b0;
            ewreg     <= 1'b0;
            em2reg    <= 1'b0;
            ewmem     <= 1'b0;
            ejal      <= 1'b0;
            ern0      <= '0;
            stall_cnt <= '0;
        end else begin
            ea      <= w_fwd_a;
            eb      <= w_fwd_b;
            eimm    <= dimm;
            esa     <= dsa;
            epc4    <= dpc4;
            ealuc   <= daluc;
            ealuimm <= daluimm;
            eshift  <= dshift;
            {ewreg, em2reg, ewmem, ejal, ern0} <= w_next_ctrl;
            if (dstall && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + c_CNT_ONE;
        end
    end

endmodule

`default_nettype wire
